// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared FSM state encoding and default widths for the dual-MAC sequencer
package mac_seq_pkg;
  localparam int OP_W = 8;
  // 16-bit products summed over up to 8 terms need 3 guard bits
  localparam int ACC_W_DEF = 2 * OP_W + 3;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, CAPTURE, WR0, WR1, DONE} state_t;
endpackage

// File: rtl/mac_pair_sequencer_if.sv
// mac_pair_sequencer_if: operand-read, MAC-control and result-write bus of the sequencer
interface mac_pair_sequencer_if import mac_seq_pkg::*; #(
  parameter int AW = 6,
  parameter int ACC_W = ACC_W_DEF
);
  logic [AW-1:0] addr_a, addr_b0, addr_b1, wr_addr;
  logic mac_clr, mac_en, wr_valid, wr_ready;
  logic signed [ACC_W-1:0] acc_a, acc_b, wr_data;
  modport master (
    output addr_a, addr_b0, addr_b1, mac_clr, mac_en, wr_valid, wr_addr, wr_data,
    input acc_a, acc_b, wr_ready
  );
  modport slave (
    input addr_a, addr_b0, addr_b1, mac_clr, mac_en, wr_valid, wr_addr, wr_data,
    output acc_a, acc_b, wr_ready
  );
endinterface

// File: rtl/mac_seq_addr_gen.sv
// mac_seq_addr_gen: i/j/k loop counters with registered operand and result-pair addresses
module mac_seq_addr_gen #(
  parameter int N = 4,
  parameter int AW = 6
) (
  input logic clk,
  input logic reset,
  input logic clear,
  input logic step_k,
  input logic step_pair,
  output logic last_k,
  output logic last_pair,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b0,
  output logic [AW-1:0] addr_b1,
  output logic [AW-1:0] pair_addr
);
  localparam logic [AW-1:0] NW = AW'(N);
  localparam logic [AW-1:0] NM1 = AW'(N - 1);
  localparam logic [AW-1:0] NM2 = AW'(N - 2);
  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [AW-1:0] TWO = AW'(2);
  logic [AW-1:0] i, j, k, i_n, j_n, k_n;
  logic row_end;
  assign last_k = k == NM1;
  assign row_end = j == NM2;
  assign last_pair = i == NM1 && row_end;
  always_comb begin
    k_n = clear ? '0 : step_k ? (last_k ? '0 : k + ONE) : k;
    j_n = clear ? '0 : step_pair ? (row_end ? '0 : j + TWO) : j;
    i_n = clear ? '0 : (step_pair && row_end) ? (i == NM1 ? '0 : i + ONE) : i;
  end
  // addresses only move with the counters so they stay at 0 from reset until the first start
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {i, j, k} <= '0;
      {addr_a, addr_b0, addr_b1, pair_addr} <= '0;
    end else if (clear || step_k || step_pair) begin
      i <= i_n;
      j <= j_n;
      k <= k_n;
      addr_a <= i_n * NW + k_n;
      addr_b0 <= k_n * NW + j_n;
      addr_b1 <= k_n * NW + j_n + ONE;
      pair_addr <= i_n * NW + j_n;
    end
endmodule

// File: rtl/mac_pair_sequencer.sv
// mac_pair_sequencer: FSM sequencing C = A x B on two MACs and serializing results to a write port
// Optional MAC_SEQ_PERF_EN adds a saturating 16-bit write-stall counter output stall_cnt.
module mac_pair_sequencer import mac_seq_pkg::*; #(
  parameter int N = 4,
  parameter int AW = 6,
  parameter int ACC_W = ACC_W_DEF
) (
  input logic clk,
  input logic reset,
  input logic start,
  output logic busy,
  output logic done,
`ifdef MAC_SEQ_PERF_EN
  output logic [15:0] stall_cnt,
`endif
  mac_pair_sequencer_if.master bus
);
  localparam logic [AW-1:0] ONE = AW'(1);
  state_t state, nxt;
  logic clear, step_k, step_pair, last_k, last_pair;
  logic busy_d, done_d, clr_d, valid_d;
  logic [AW-1:0] pair_addr, wr_addr_d;
  logic signed [ACC_W-1:0] cap_b, wr_data_d;

  assign clear = state == IDLE && start;
  assign step_k = state == FETCH;
  assign step_pair = state == WR1 && bus.wr_ready;

  mac_seq_addr_gen #(.N(N), .AW(AW)) u_addr_gen (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .step_k(step_k),
    .step_pair(step_pair),
    .last_k(last_k),
    .last_pair(last_pair),
    .addr_a(bus.addr_a),
    .addr_b0(bus.addr_b0),
    .addr_b1(bus.addr_b1),
    .pair_addr(pair_addr)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? CLEAR : IDLE;
      CLEAR: nxt = FETCH;
      FETCH: nxt = last_k ? DRAIN : FETCH;
      DRAIN: nxt = CAPTURE;
      CAPTURE: nxt = WR0;
      WR0: nxt = bus.wr_ready ? WR1 : WR0;
      WR1: nxt = bus.wr_ready ? (last_pair ? DONE : CLEAR) : WR1;
      default: nxt = IDLE;
    endcase
  end

  // outputs are decoded from the next state so the registered copies line up with the state
  always_comb begin
    busy_d = nxt != IDLE;
    done_d = nxt == DONE;
    clr_d = nxt == CLEAR;
    valid_d = nxt == WR0 || nxt == WR1;
    wr_addr_d = nxt == WR0 ? pair_addr : nxt == WR1 ? pair_addr + ONE : bus.wr_addr;
    wr_data_d = state == CAPTURE ? bus.acc_a : (state == WR0 && bus.wr_ready) ? cap_b : bus.wr_data;
  end

  // mac_en trails FETCH by one cycle to match the one-cycle operand read latency
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      bus.mac_clr <= 1'b0;
      bus.mac_en <= 1'b0;
      bus.wr_valid <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      cap_b <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      bus.mac_clr <= clr_d;
      bus.mac_en <= state == FETCH;
      bus.wr_valid <= valid_d;
      bus.wr_addr <= wr_addr_d;
      bus.wr_data <= wr_data_d;
      cap_b <= state == CAPTURE ? bus.acc_b : cap_b;
    end

`ifdef MAC_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_cnt <= '0;
    else if (clear) stall_cnt <= '0;
    else if (bus.wr_valid && !bus.wr_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_mac_pair_sequencer.sv
// tb_mac_pair_sequencer: directed bench with operand memories and MAC models around the sequencer
module tb_mac_pair_sequencer;
  logic clk, reset, start, busy, done;
`ifdef MAC_SEQ_PERF_EN
  logic [15:0] stall_cnt;
`endif
  mac_pair_sequencer_if #(.AW(6), .ACC_W(19)) bus ();

  mac_pair_sequencer #(.N(4), .AW(6), .ACC_W(19)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
`ifdef MAC_SEQ_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .bus(bus.master)
  );

  logic signed [7:0] mem_a [64];
  logic signed [7:0] mem_b [64];
  logic signed [7:0] a_q, b0_q, b1_q;
  logic [5:0] log_addr [256];
  logic signed [18:0] log_data [256];
  int nwr = 0;
  int n_checks = 0;
  int n_err = 0;
  int lat, base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one-cycle-latency operand memories feeding two accumulating MACs
  always @(posedge clk) begin
    a_q <= mem_a[bus.addr_a];
    b0_q <= mem_b[bus.addr_b0];
    b1_q <= mem_b[bus.addr_b1];
    if (bus.mac_clr) begin
      bus.acc_a <= '0;
      bus.acc_b <= '0;
    end else if (bus.mac_en) begin
      bus.acc_a <= bus.acc_a + 19'(a_q) * 19'(b0_q);
      bus.acc_b <= bus.acc_b + 19'(a_q) * 19'(b1_q);
    end
  end

  always @(negedge clk)
    if (!reset && bus.wr_valid && bus.wr_ready) begin
      if (nwr < 256) begin
        log_addr[nwr] = bus.wr_addr;
        log_data[nwr] = bus.wr_data;
      end
      nwr++;
    end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_mac_clr"}, bus.mac_clr, 0);
    check({p, "_mac_en"}, bus.mac_en, 0);
    check({p, "_wr_valid"}, bus.wr_valid, 0);
    check({p, "_addr_a"}, bus.addr_a, 0);
    check({p, "_addr_b0"}, bus.addr_b0, 0);
    check({p, "_addr_b1"}, bus.addr_b1, 0);
    check({p, "_wr_addr"}, bus.wr_addr, 0);
    check({p, "_wr_data"}, bus.wr_data, 0);
  endtask

  task automatic load(input bit neg);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem_a[r * 4 + c] = neg ? -8'sd128 : (r == c ? 8'sd1 : 8'sd0);
        mem_b[r * 4 + c] = neg ? -8'sd128 : 8'(r * 4 + c);
      end
  endtask

  task automatic run_mult(output int l);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_busy", busy, 1);
    check("start_clr", bus.mac_clr, 1);
    l = 0;
    while (!done && l < 400) begin
      @(posedge clk);
      #1 l++;
    end
    check("done_busy", busy, 1);
  endtask

  task automatic check_writes(input int b, input bit neg);
    check("n_writes", nwr - b, 16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("wr_addr[%0d]", k), log_addr[b + k], k);
      check($sformatf("wr_data[%0d]", k), log_data[b + k], neg ? 65536 : k);
    end
  endtask

  task automatic stall5();
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!(bus.wr_valid && bus.wr_addr == 6) && n < 300);
    bus.wr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", bus.wr_valid, 1);
      check("stall_addr", bus.wr_addr, 6);
      check("stall_data", bus.wr_data, 6);
      check("stall_mac_en", bus.mac_en, 0);
    end
    @(posedge clk);
    #1 bus.wr_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    bus.wr_ready = 1'b1;
    load(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("idle");

    base = nwr;
    run_mult(lat);
    check("lat_ident", lat, 72);
    check_writes(base, 1'b0);

    load(1'b1);
    base = nwr;
    run_mult(lat);
    check("lat_neg", lat, 72);
    check_writes(base, 1'b1);

    load(1'b0);
    base = nwr;
    fork
      run_mult(lat);
      stall5();
    join
    check("lat_stall", lat, 77);
    check_writes(base, 1'b0);
`ifdef MAC_SEQ_PERF_EN
    check("stall_cnt", stall_cnt, 5);
`endif

    base = nwr;
    fork
      run_mult(lat);
      begin
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    check("lat_busy_start", lat, 72);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_start_busy", busy, 0);
    check("done_start_done", done, 0);
    repeat (5) @(posedge clk);
    #1 check("after_done_busy", busy, 0);
    check_writes(base, 1'b0);

    base = nwr;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (bus.addr_a != 9 && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    check("abort_fetch_addr", bus.addr_a, 9);
    reset = 1'b1;
    @(negedge clk);
    check_zero("abort");
    check("abort_writes", nwr - base, 8);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_idle_busy", busy, 0);
    check("abort_no_more_writes", nwr - base, 8);

    base = nwr;
    run_mult(lat);
    check("lat_restart", lat, 72);
    check_writes(base, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
